// File: rtl/comm_resp.sv
// Copter-side command link responder: 8N1 UART receiver with a 3-byte frame assembler and a
// single-byte response transmitter. RX and TX run independently.
module comm_resp #(
    parameter int unsigned BAUD_DIV  = 2604,
    parameter logic [19:0] FRAME_TMO = 20'd500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam logic [11:0] BitLast  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HalfLast = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {FaByte0, FaByte1, FaByte2} fa_state_e;
    typedef enum logic {TxIdle, TxXmit} tx_state_e;

    // ---------------- RX synchronizer and bit FSM ----------------
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [11:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bits_q, rx_bits_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        stop_err_q, stop_err_d;
    logic        byte_rdy_q, byte_rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        fall, start_det;

    assign fall = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bits_d  = rx_bits_q;
        rx_shift_d = rx_shift_q;
        stop_err_d = stop_err_q;
        byte_rdy_d = 1'b0;
        frm_err_d  = 1'b0;
        start_det  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                stop_err_d = 1'b0;
                if (fall) begin
                    start_det  = 1'b1;
                    rx_cnt_d   = HalfLast;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == 12'd0) begin
                    if (rx_sync_q) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_cnt_d   = BitLast;
                        rx_bits_d  = 3'd0;
                        rx_state_d = RxData;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 12'd1;
                end
            end
            RxData: begin
                if (rx_cnt_q == 12'd0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BitLast;
                    if (rx_bits_q == 3'd7) rx_state_d = RxStop;
                    else                   rx_bits_d  = rx_bits_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 12'd1;
                end
            end
            RxStop: begin
                // After a framing error, hold here until the line returns high.
                if (stop_err_q) begin
                    if (rx_sync_q) rx_state_d = RxIdle;
                end else if (rx_cnt_q == 12'd0) begin
                    if (rx_sync_q) begin
                        byte_rdy_d = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        stop_err_d = 1'b1;
                        frm_err_d  = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 12'd1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= 12'd0;
            rx_bits_q  <= 3'd0;
            rx_shift_q <= 8'd0;
            stop_err_q <= 1'b0;
            byte_rdy_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bits_q  <= rx_bits_d;
            rx_shift_q <= rx_shift_d;
            stop_err_q <= stop_err_d;
            byte_rdy_q <= byte_rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // ---------------- Frame assembler ----------------
    fa_state_e   fa_state_q, fa_state_d;
    logic [7:0]  cmd_sh_q, cmd_sh_d, hi_sh_q, hi_sh_d;
    logic [19:0] gap_q, gap_d, gap_inc;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frame_done;

    assign gap_inc = gap_q + 20'd1;

    always_comb begin
        fa_state_d = fa_state_q;
        cmd_sh_d   = cmd_sh_q;
        hi_sh_d    = hi_sh_q;
        gap_d      = 20'd0;
        cmd_d      = cmd_q;
        data_d     = data_q;
        frame_done = 1'b0;
        if (frm_err_q) begin
            fa_state_d = FaByte0;
        end else if (byte_rdy_q) begin
            unique case (fa_state_q)
                FaByte0: begin
                    cmd_sh_d   = rx_shift_q;
                    fa_state_d = FaByte1;
                end
                FaByte1: begin
                    hi_sh_d    = rx_shift_q;
                    fa_state_d = FaByte2;
                end
                default: begin
                    cmd_d      = cmd_sh_q;
                    data_d     = {hi_sh_q, rx_shift_q};
                    frame_done = 1'b1;
                    fa_state_d = FaByte0;
                end
            endcase
        end else if (fa_state_q != FaByte0 && rx_state_q == RxIdle) begin
            if (gap_inc == FRAME_TMO) fa_state_d = FaByte0;
            else                      gap_d      = gap_inc;
        end
        if (frame_done)                                       cmd_rdy_d = 1'b1;
        else if (clr_cmd_rdy || (start_det && fa_state_q == FaByte0)) cmd_rdy_d = 1'b0;
        else                                                  cmd_rdy_d = cmd_rdy_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fa_state_q <= FaByte0;
            cmd_sh_q   <= 8'd0;
            hi_sh_q    <= 8'd0;
            gap_q      <= 20'd0;
            cmd_q      <= 8'd0;
            data_q     <= 16'd0;
            cmd_rdy_q  <= 1'b0;
        end else begin
            fa_state_q <= fa_state_d;
            cmd_sh_q   <= cmd_sh_d;
            hi_sh_q    <= hi_sh_d;
            gap_q      <= gap_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            cmd_rdy_q  <= cmd_rdy_d;
        end
    end

    assign cmd     = cmd_q;
    assign data    = data_q;
    assign cmd_rdy = cmd_rdy_q;

    // ---------------- TX path ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [9:0]  tx_shift_q, tx_shift_d;
    logic [11:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bits_q, tx_bits_d;
    logic        resp_sent_q, resp_sent_d;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bits_d   = tx_bits_q;
        resp_sent_d = resp_sent_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (send_resp) begin
                    tx_shift_d  = {1'b1, resp, 1'b0};
                    tx_cnt_d    = 12'd0;
                    tx_bits_d   = 4'd0;
                    resp_sent_d = 1'b0;
                    tx_state_d  = TxXmit;
                end
            end
            default: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = 12'd0;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    if (tx_bits_q == 4'd9) begin
                        resp_sent_d = 1'b1;
                        tx_state_d  = TxIdle;
                    end else begin
                        tx_bits_d = tx_bits_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 12'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q  <= TxIdle;
            tx_shift_q  <= 10'h3FF;
            tx_cnt_q    <= 12'd0;
            tx_bits_q   <= 4'd0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bits_q   <= tx_bits_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign TX        = (tx_state_q == TxXmit) ? tx_shift_q[0] : 1'b1;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_comm_resp.sv
// Directed bench for comm_resp: frames, framing errors, glitches, gap timeout, TX and reset.
module tb_comm_resp;

    localparam int unsigned Baud = 16;
    localparam logic [19:0] Tmo  = 20'd200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'd0;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]  c;
        logic [15:0] d;
    } frame_t;

    frame_t exp_q[$];
    logic   tx_exp_q[$];

    always #5 clk = ~clk;

    comm_resp #(
        .BAUD_DIV (Baud),
        .FRAME_TMO(Tmo)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .data       (data),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 byte aligned to clk; optionally checks cmd_rdy around the stop sample.
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit chk_tm);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int t = 0; t < 10 * Baud; t++) begin
            RX = bits[t / Baud];
            @(posedge clk); #1;
            if (chk_tm && t == Baud / 2 + 2 + 9 * Baud) chk("rdy_before_edge", 24'(cmd_rdy), 24'd0);
            if (chk_tm && t == Baud / 2 + 3 + 9 * Baud) chk("rdy_at_edge", 24'(cmd_rdy), 24'd1);
        end
        RX = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                              input bit chk_tm);
        exp_q.push_back({c, h, l});
        send_byte(c, 1'b1, 1'b0);
        send_byte(h, 1'b1, 1'b0);
        send_byte(l, 1'b1, chk_tm);
    endtask

    task automatic wait_frame(input string tag);
        frame_t e;
        int     n;
        n = 0;
        while (!cmd_rdy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rdy"}, 24'(cmd_rdy), 24'd1);
        e = exp_q.pop_front();
        chk({tag, "_cmd"}, 24'(cmd), 24'(e.c));
        chk({tag, "_data"}, 24'(data), 24'(e.d));
    endtask

    task automatic clear_rdy();
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] txf;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 24'(TX), 24'd1);
        chk("rst_cmd", 24'(cmd), 24'd0);
        chk("rst_data", 24'(data), 24'd0);
        chk("rst_rdy", 24'(cmd_rdy), 24'd0);
        chk("rst_sent", 24'(resp_sent), 24'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: basic frame, exact cmd_rdy timing, clear
        send_frame(8'h02, 8'h00, 8'h2A, 1'b1);
        wait_frame("t1");
        clear_rdy();
        chk("t1_clr", 24'(cmd_rdy), 24'd0);

        // 2: back-to-back frames without clearing
        send_frame(8'h04, 8'hFF, 8'h1F, 1'b0);
        wait_frame("t2a");
        exp_q.push_back({8'h03, 8'h00, 8'h3A});
        send_byte(8'h03, 1'b1, 1'b0);
        chk("t2_drop", 24'(cmd_rdy), 24'd0);
        chk("t2_cmd_hold", 24'(cmd), 24'h04);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h3A, 1'b1, 1'b0);
        wait_frame("t2b");

        // 3a: framing error then a good frame
        clear_rdy();
        send_byte(8'h05, 1'b0, 1'b0);
        repeat (2 * Baud) @(posedge clk);
        #1;
        chk("t3_ferr_rdy", 24'(cmd_rdy), 24'd0);
        send_frame(8'h06, 8'h00, 8'h00, 1'b0);
        wait_frame("t3a");

        // 3b: quarter-bit glitch must not be taken as a byte
        clear_rdy();
        @(posedge clk); #1;
        RX = 1'b0;
        repeat (Baud / 4) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (3 * Baud) @(posedge clk);
        #1;
        chk("t3_glitch_rdy", 24'(cmd_rdy), 24'd0);
        send_frame(8'h09, 8'h11, 8'h22, 1'b0);
        wait_frame("t3b");

        // 4: inter-byte gap timeout discards partial frame
        clear_rdy();
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        repeat (int'(Tmo) + 1) @(posedge clk);
        #1;
        chk("t4_tmo_rdy", 24'(cmd_rdy), 24'd0);
        exp_q.push_back({8'h08, 8'hAB, 8'hCD});
        send_byte(8'h08, 1'b1, 1'b0);
        chk("t4_no_stale", 24'(cmd_rdy), 24'd0);
        send_byte(8'hAB, 1'b1, 1'b0);
        send_byte(8'hCD, 1'b1, 1'b0);
        wait_frame("t4");

        // 5: response transmit, second request ignored
        @(posedge clk); #1;
        resp = 8'hA5;
        send_resp = 1'b1;
        txf = {1'b1, resp, 1'b0};
        for (int i = 0; i < 10; i++) tx_exp_q.push_back(txf[i]);
        @(posedge clk); #1;
        send_resp = 1'b0;
        for (int c = 1; c <= 170; c++) begin
            if (c == 50) begin
                resp = 8'h00;
                send_resp = 1'b1;
            end
            @(posedge clk); #1;
            send_resp = 1'b0;
            if (c % Baud == Baud / 2 && c < 10 * Baud) begin
                chk("t5_tx_bit", 24'(TX), 24'(tx_exp_q.pop_front()));
            end
            if (c == 10 * Baud - 1) chk("t5_sent_early", 24'(resp_sent), 24'd0);
            if (c == 10 * Baud) chk("t5_sent", 24'(resp_sent), 24'd1);
            if (c == 170) chk("t5_tx_idle", 24'(TX), 24'd1);
        end

        // 6: reset mid-RX byte and mid-TX
        resp = 8'h00;
        send_resp = 1'b1;
        @(posedge clk); #1;
        send_resp = 1'b0;
        @(posedge clk); #1;
        chk("t6_sent_clr", 24'(resp_sent), 24'd0);
        RX = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t6_tx_busy", 24'(TX), 24'd0);
        rst_n = 1'b0;
        RX = 1'b1;
        @(posedge clk); #1;
        chk("t6_tx", 24'(TX), 24'd1);
        chk("t6_rdy", 24'(cmd_rdy), 24'd0);
        chk("t6_sent", 24'(resp_sent), 24'd0);
        chk("t6_cmd", 24'(cmd), 24'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_tx_idle", 24'(TX), 24'd1);
        send_frame(8'h07, 8'h00, 8'h00, 1'b0);
        wait_frame("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
